// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted load-use bubbles.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [2:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_Read1,
    input  logic [DATA_W-1:0] ID_Read2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic [4:0]        IF_ID_Rd,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemToReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic [2:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] ID_EX_Read1,
    output logic [DATA_W-1:0] ID_EX_Read2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PCPlus4,
    output logic [4:0]        ID_EX_Rs,
    output logic [4:0]        ID_EX_Rt,
    output logic [4:0]        ID_EX_Rd,
    output logic              ID_EX_Valid,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic [CNT_W-1:0]  StallCount
);

    logic             w_load_use;
    logic             w_bubble;
    logic             w_cnt_sat;
    logic [CNT_W-1:0] r_stall_cnt;

    // Rt compare is deliberately conservative: I-type destinations in Rt also stall.
    assign w_load_use = ID_EX_MemRead & ID_EX_Valid & (ID_EX_Rt != 5'd0) &
                        ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt));
    assign w_bubble   = flush | w_load_use;
    assign w_cnt_sat  = &r_stall_cnt;

    // Flush does not gate the front end; the branch logic owns the redirect.
    assign PCWrite    = ~hold & ~w_load_use;
    assign IF_IDWrite = ~hold & ~w_load_use;
    assign StallCount = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_MemToReg <= 1'b0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_RegDst   <= 1'b0;
            ID_EX_ALUOp    <= 3'd0;
            ID_EX_Read1    <= '0;
            ID_EX_Read2    <= '0;
            ID_EX_Imm      <= '0;
            ID_EX_PCPlus4  <= '0;
            ID_EX_Rs       <= 5'd0;
            ID_EX_Rt       <= 5'd0;
            ID_EX_Rd       <= 5'd0;
            ID_EX_Valid    <= 1'b0;
            r_stall_cnt    <= '0;
        end else if (!hold) begin
            ID_EX_RegWrite <= ID_RegWrite & ~w_bubble;
            ID_EX_MemRead  <= ID_MemRead  & ~w_bubble;
            ID_EX_MemWrite <= ID_MemWrite & ~w_bubble;
            ID_EX_MemToReg <= ID_MemToReg & ~w_bubble;
            ID_EX_ALUSrc   <= ID_ALUSrc   & ~w_bubble;
            ID_EX_RegDst   <= ID_RegDst   & ~w_bubble;
            ID_EX_ALUOp    <= w_bubble ? 3'd0 : ID_ALUOp;
            ID_EX_Read1    <= w_bubble ? '0 : ID_Read1;
            ID_EX_Read2    <= w_bubble ? '0 : ID_Read2;
            ID_EX_Imm      <= w_bubble ? '0 : ID_Imm;
            ID_EX_PCPlus4  <= w_bubble ? '0 : ID_PCPlus4;
            ID_EX_Rs       <= w_bubble ? 5'd0 : IF_ID_Rs;
            ID_EX_Rt       <= w_bubble ? 5'd0 : IF_ID_Rt;
            ID_EX_Rd       <= w_bubble ? 5'd0 : IF_ID_Rd;
            ID_EX_Valid    <= ~w_bubble;
            // A flush already squashes the slot, so the coincident stall is not counted.
            if (!flush && w_load_use && !w_cnt_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
